// File: rtl/bcd_seg_driver_pkg.sv
// Shared types, segment constants and the digit decoder for bcd_seg_driver.
// Segment vectors are {g,f,e,d,c,b,a} with a lit segment as 1; polarity is applied at the top.
package bcd_seg_driver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV_PC,
        CONV_REG,
        UPDATE
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_F     = 7'b1110001;

    localparam int unsigned ITER_COUNT = 7;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    function automatic logic [6:0] seg_drive(input logic [6:0] seg, input bit active_low);
        return active_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/bcd_seg_driver_bin2bcd_seq.sv
// Sequential double-dabble: converts a 7-bit binary value to two BCD digits,
// one shift-and-add-3 iteration per step cycle.
module bin2bcd_seq
    import bcd_seg_driver_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_step,
    input  logic [6:0] i_bin,
    output logic       o_busy,
    output logic       o_last,
    output logic [7:0] o_bcd,
    output logic [7:0] o_bcd_next
);

    logic [7:0] r_bcd;
    logic [6:0] r_bin;
    logic [2:0] r_cnt;

    logic [3:0] w_units;
    logic [3:0] w_tens;
    logic [7:0] w_bcd_next;
    logic [6:0] w_bin_next;

    always_comb begin
        w_units    = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
        w_tens     = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
        // Hundreds carry is dropped: only values up to 99 are ever displayed.
        w_bcd_next = {w_tens[2:0], w_units, r_bin[6]};
        w_bin_next = {r_bin[5:0], 1'b0};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bcd <= 8'd0;
            r_bin <= 7'd0;
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_bcd <= 8'd0;
            r_bin <= i_bin;
            r_cnt <= 3'(ITER_COUNT);
        end else if (i_step && (r_cnt != 3'd0)) begin
            r_bcd <= w_bcd_next;
            r_bin <= w_bin_next;
            r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_busy     = (r_cnt != 3'd0);
    assign o_last     = (r_cnt == 3'd1);
    assign o_bcd      = r_bcd;
    assign o_bcd_next = w_bcd_next;

endmodule

// File: rtl/bcd_seg_driver.sv
// Captures pc/register on start, converts both through one shared double-dabble
// engine and drives four digit displays plus an end-of-execution indicator.
module bcd_seg_driver
    import bcd_seg_driver_pkg::*;
#(
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned MAX_VAL        = 99
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic [31:0] register,
    input  logic        final_flag,  // end-of-execution flag from the datapath FSM
    output logic        busy,
    output logic        done,
    output logic [6:0]  display1,
    output logic [6:0]  display2,
    output logic [6:0]  display3,
    output logic [6:0]  display4,
    output logic [6:0]  display5
);

    localparam logic [6:0] BLANK = seg_drive(SEG_BLANK, SEG_ACTIVE_LOW);
    localparam logic [6:0] DASH  = seg_drive(SEG_DASH, SEG_ACTIVE_LOW);
    localparam logic [6:0] FSEG  = seg_drive(SEG_F, SEG_ACTIVE_LOW);

    state_e     r_state;
    state_e     w_state_next;
    logic [6:0] r_reg_bin;
    logic       r_pc_ovf;
    logic       r_reg_ovf;
    logic [7:0] r_pc_bcd;
    logic       r_done;
    logic [6:0] r_disp1, r_disp2, r_disp3, r_disp4, r_disp5;

    logic       w_load;
    logic       w_step;
    logic [6:0] w_bin;
    logic       w_cvt_busy;
    logic       w_cvt_last;
    logic [7:0] w_cvt_bcd;
    logic [7:0] w_cvt_bcd_next;

    // Returns {tens, units} segment patterns with polarity applied.
    function automatic logic [13:0] digit_pair(input logic [7:0] bcd, input logic ovf);
        if (ovf) begin
            return {DASH, DASH};
        end
        return {seg_drive(seg_decode(bcd[7:4]), SEG_ACTIVE_LOW),
                seg_drive(seg_decode(bcd[3:0]), SEG_ACTIVE_LOW)};
    endfunction

    bin2bcd_seq u_bin2bcd (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_bin      (w_bin),
        .o_busy     (w_cvt_busy),
        .o_last     (w_cvt_last),
        .o_bcd      (w_cvt_bcd),
        .o_bcd_next (w_cvt_bcd_next)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_bin        = pc[6:0];
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = CONV_PC;
                    w_load       = 1'b1;
                end
            end
            CONV_PC: begin
                w_step = w_cvt_busy;
                // Last pc iteration is taken from o_bcd_next while the engine reloads.
                if (w_cvt_last) begin
                    w_state_next = CONV_REG;
                    w_load       = 1'b1;
                    w_bin        = r_reg_bin;
                end
            end
            CONV_REG: begin
                w_step = w_cvt_busy;
                if (w_cvt_last) begin
                    w_state_next = UPDATE;
                end
            end
            UPDATE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_reg_bin <= 7'd0;
            r_pc_ovf  <= 1'b0;
            r_reg_ovf <= 1'b0;
            r_pc_bcd  <= 8'd0;
            r_done    <= 1'b0;
            r_disp1   <= BLANK;
            r_disp2   <= BLANK;
            r_disp3   <= BLANK;
            r_disp4   <= BLANK;
            r_disp5   <= BLANK;
        end else begin
            r_state <= w_state_next;
            r_done  <= (r_state == UPDATE);
            r_disp5 <= final_flag ? FSEG : BLANK;
            if ((r_state == IDLE) && start) begin
                r_reg_bin <= register[6:0];
                r_pc_ovf  <= (pc > 32'(MAX_VAL));
                r_reg_ovf <= (register > 32'(MAX_VAL));
            end
            if ((r_state == CONV_PC) && w_cvt_last) begin
                r_pc_bcd <= w_cvt_bcd_next;
            end
            if (r_state == UPDATE) begin
                {r_disp2, r_disp1} <= digit_pair(r_pc_bcd, r_pc_ovf);
                {r_disp4, r_disp3} <= digit_pair(w_cvt_bcd, r_reg_ovf);
            end
        end
    end

    assign busy     = (r_state != IDLE);
    assign done     = r_done;
    assign display1 = r_disp1;
    assign display2 = r_disp2;
    assign display3 = r_disp3;
    assign display4 = r_disp4;
    assign display5 = r_disp5;

endmodule

// File: tb/tb_bcd_seg_driver.sv
// Scoreboard bench for bcd_seg_driver: the driver pushes expected displays per accepted
// start, a monitor pops them on done and checks displays, display5 and done every cycle.
module tb_bcd_seg_driver;

    localparam int unsigned MAX_VAL = 99;
    localparam logic [6:0] BLANK_AL = 7'b1111111;
    localparam logic [6:0] DASH_AL  = 7'b0111111;
    localparam logic [6:0] F_AL     = 7'b0001110;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic [31:0] register;
    logic        final_flag;
    logic        busy;
    logic        done;
    logic [6:0]  display1, display2, display3, display4, display5;

    int n_tests = 0;
    int n_fail  = 0;

    logic [27:0] exp_q [$];
    logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    logic e_rst;
    logic e_fin;

    bcd_seg_driver #(
        .SEG_ACTIVE_LOW (1'b1),
        .MAX_VAL        (MAX_VAL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pc         (pc),
        .register   (register),
        .final_flag (final_flag),
        .busy       (busy),
        .done       (done),
        .display1   (display1),
        .display2   (display2),
        .display3   (display3),
        .display4   (display4),
        .display5   (display5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {tens, units} of one operand as active-low segment patterns.
    function automatic logic [13:0] pair_model(input logic [31:0] v);
        int d;
        if (v > 32'(MAX_VAL)) return {DASH_AL, DASH_AL};
        d = int'(v);
        return {seg_tab[d / 10], seg_tab[d % 10]};
    endfunction

    // {display4, display3, display2, display1}
    function automatic logic [27:0] model(input logic [31:0] p, input logic [31:0] r);
        return {pair_model(r), pair_model(p)};
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 99));
            1:       return 32'($urandom_range(100, 127));
            2:       return 32'($urandom_range(128, 1000));
            default: return $urandom();
        endcase
    endfunction

    // Input values seen at each rising edge, for the monitor's per-cycle model.
    initial forever begin
        @(posedge clk);
        e_rst = !rst;
        e_fin = final_flag;
    end

    initial forever begin
        @(negedge clk);
        final_flag = 1'($urandom_range(0, 1));
    end

    initial begin : monitor
        logic [27:0] cur;
        logic        prev_done;
        cur       = {4{BLANK_AL}};
        prev_done = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("display5", 32'(display5), 32'((!e_rst && e_fin) ? F_AL : BLANK_AL));
            if (e_rst) begin
                cur = {4{BLANK_AL}};
                chk("reset_done", 32'(done), 32'd0);
                chk("reset_busy", 32'(busy), 32'd0);
            end else if (done) begin
                chk("done_single_cycle", 32'(prev_done), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            chk("displays", 32'({display4, display3, display2, display1}), 32'(cur));
            prev_done = done;
        end
    end

    // One conversion; optionally a second start with pc=cp issued to land on edge N+conflict_k.
    task automatic convert(input logic [31:0] p, input logic [31:0] r,
                           input int conflict_k, input logic [31:0] cp);
        @(negedge clk);
        pc       = p;
        register = r;
        start    = 1'b1;
        exp_q.push_back(model(p, r));
        @(posedge clk);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == conflict_k - 1) begin
                pc    = cp;
                start = 1'b1;
            end
            chk("busy_during", 32'(busy), 32'd1);
            chk("done_early", 32'(done), 32'd0);
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy_end", 32'(busy), 32'd0);
        chk("done_latency", 32'(done), 32'd1);
    endtask

    initial begin : driver
        logic [31:0] pb, rb;
        rst        = 1'b0;
        start      = 1'b0;
        pc         = 32'd0;
        register   = 32'd0;
        final_flag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_disp1", 32'(display1), 32'(BLANK_AL));
        chk("rst_disp2", 32'(display2), 32'(BLANK_AL));
        chk("rst_disp3", 32'(display3), 32'(BLANK_AL));
        chk("rst_disp4", 32'(display4), 32'(BLANK_AL));
        chk("rst_disp5", 32'(display5), 32'(BLANK_AL));
        rst = 1'b1;
        repeat (2) @(negedge clk);

        convert(32'd37, 32'd5, -1, 32'd0);
        convert(32'd100, 32'd99, -1, 32'd0);
        convert(32'd12, 32'd0, 3, 32'd34);
        convert(32'd34, 32'd0, -1, 32'd0);

        // start held high: a second capture on the first cycle back in IDLE.
        pb = 32'd81;
        rb = 32'd250;
        @(negedge clk);
        pc       = 32'd7;
        register = 32'd64;
        start    = 1'b1;
        exp_q.push_back(model(32'd7, 32'd64));
        @(posedge clk);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 5) begin
                pc       = pb;
                register = rb;
                exp_q.push_back(model(pb, rb));
            end
            if (k == 15) begin
                chk("held_done1", 32'(done), 32'd1);
                chk("held_idle", 32'(busy), 32'd0);
            end
            if (k == 16) begin
                chk("held_restart", 32'(busy), 32'd1);
                start = 1'b0;
            end
            if (k == 31) chk("held_done2", 32'(done), 32'd1);
        end

        // Reset in the middle of a conversion.
        @(negedge clk);
        pc       = 32'd55;
        register = 32'd66;
        start    = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 4) rst = 1'b0;
        end
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_disp", 32'({display4, display3, display2, display1}), 32'({4{BLANK_AL}}));
        rst = 1'b1;
        repeat (20) @(negedge clk);
        convert(32'd37, 32'd5, -1, 32'd0);

        for (int i = 0; i < 40; i++) begin
            int ck;
            ck = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1;
            convert(rand_val(), rand_val(), ck, rand_val());
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_seg_driver.md
BCD_SEG_DRIVER -- requirements
Module: bcd_seg_driver

Interface
REQ-001 Parameter SEG_ACTIVE_LOW, default 1; when 1, a lit segment is driven 0.
REQ-002 Parameter MAX_VAL, default 99; this is the largest value shown as two decimal digits.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 Port start, input, 1 bit: request to capture pc and register and convert them.
REQ-006 Port pc, input, 32 bits: program counter value to display.
REQ-007 Port register, input, 32 bits: register value to display (x5 in the datapath).
REQ-008 Port final, input, 1 bit: end-of-execution flag from the datapath FSM.
REQ-009 Port busy, output, 1 bit: a conversion is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse; displays were just updated.
REQ-011 Ports display1..display5, output, 7 bits each: pc units, pc tens, register units, register tens, and the final indicator.

Function
REQ-012 Segment vector SHALL be {g,f,e,d,c,b,a}, with bit 0 = a; the polarity is set by SEG_ACTIVE_LOW.
REQ-013 FSM states SHALL be IDLE, CONV_PC, CONV_REG and UPDATE.
REQ-014 FSM transitions SHALL be:
- IDLE to CONV_PC on start=1;
- CONV_PC to CONV_REG after 7 iterations;
- CONV_REG to UPDATE after 7 iterations;
- UPDATE to IDLE unconditionally.
REQ-015 At the edge N where start=1 is sampled in IDLE, the block SHALL latch pc and register and flag each as overflow if its value > MAX_VAL.
REQ-016 Conversion SHALL be shift-and-add-3 (double-dabble) on bits [6:0], one iteration per cycle, with add-3 applied to each BCD nibble ≥5 before the shift.
REQ-017 busy SHALL be 1 from edge N through edge N+15 (15 cycles).
REQ-018 display1..display4 SHALL update at edge N+15, and done SHALL be 1 for exactly the cycle following that edge.
REQ-019 A value flagged as overflow SHALL display a dash (segment g only) on both of its digits; leading zeros are shown (5 displays as "05").
REQ-020 start SHALL be ignored while busy=1; there is no queuing.
REQ-021 start held high continuously SHALL begin a new conversion on the first cycle back in IDLE.
REQ-022 display5 SHALL show "F" (segments a,e,f,g) when final=1 and blank otherwise, registered with 1-cycle latency and independent of the FSM.
REQ-023 display1..display4 SHALL hold their last values between conversions.

Reset
REQ-024 While rst=0 at a rising edge, the block SHALL enter IDLE, clear busy and done, and set all display outputs to blank (all segments off).
REQ-025 Reset asserted mid-conversion SHALL abort it: no done pulse, and displays are blank after reset.
REQ-026 The first conversion after reset release SHALL behave identically to REQ-015 through REQ-018.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enum;
- constants SEG_BLANK, SEG_DASH and SEG_F;
- the 4-bit digit-to-segment decode function;
- ITER_COUNT=7.
REQ-028 One sub-module, bin2bcd_seq, SHALL implement the per-cycle double-dabble step with load, step and busy control; it is instantiated once and shared by both operands.
REQ-029 This block SHALL replace the combinational digit split in the datapath top and drive its display ports directly.

Verification (SEG_ACTIVE_LOW=1)
REQ-030 Reset: rst=0 for 2 cycles -> display1..5=7'b1111111, busy=0, done=0.
REQ-031 Basic conversion: pc=37, register=5, start pulse at N -> at N+15:
- display1=7'b1111000, display2=7'b0110000;
- display3=7'b0010010, display4=7'b1000000;
- done high for one cycle.
REQ-032 Boundary: pc=100, register=99 -> display1=display2=7'b0111111; display3=display4=7'b0010000.
REQ-033 Busy conflict: pc=12 start at N, then pc=34 start at N+3 -> displays show 12 at N+15; a second start after done shows 34 fifteen cycles later.
REQ-034 Reset mid-operation: start at N, rst=0 at N+5 -> no done pulse, all displays blank, busy=0 at N+6.
REQ-035 Final flag: final=1 at edge M -> display5=7'b0001110 from edge M+1; final=0 -> 7'b1111111 one cycle later.
